// File: rtl/rv523_selftest_pkg.sv
// Shared state encoding and truth-table constants for the cell self-test engines.
// No logic: no latency, no backpressure.
package rv523_selftest_pkg;

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, FINISH} state_t;

    localparam int VEC_COUNT = 16;

    localparam logic [15:0] TRUTH_NOR4  = 16'h0001;
    localparam logic [15:0] TRUTH_NAND4 = 16'h7FFF;
    localparam logic [15:0] TRUTH_AND4  = 16'h8000;
    localparam logic [15:0] TRUTH_OR4   = 16'hFFFE;

endpackage

// File: rtl/cell4_settle_timer.sv
// 4-bit loadable up/down counter; tc is high while the count equals tc_val.
// Load/step take effect on the next clock; no backpressure.
module cell4_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       up,
    input  logic [3:0] tc_val,
    output logic       tc
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + 4'd1 : count - 4'd1;
        end
    end

    assign tc = (count == tc_val);

endmodule

// File: rtl/cell4_selftest.sv
// Self-test engine for a 4-input cell: walks vectors 0..15, samples Y after SETTLE cycles, scores vs TRUTH.
// One vector per SETTLE+2 cycles; START is ignored while a run is in progress.
module cell4_selftest #(
    parameter logic [15:0] TRUTH  = 16'h0001,
    parameter int          SETTLE = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       Y,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       A4,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [4:0] ERR_CNT,
    output logic       FAIL_VALID,
    output logic [3:0] FIRST_FAIL
);
    import rv523_selftest_pkg::*;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] LAST_VEC    = 4'(VEC_COUNT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic       y_q;
    logic       settle_done;
    logic       mismatch;
    logic       running;
    logic [4:0] err_nxt;

    // The parameter SETTLE shadows the enumerator, so the state is package-qualified.
    cell4_settle_timer u_settle (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (state == APPLY),
        .load_val (4'd0),
        .en       (state == rv523_selftest_pkg::SETTLE),
        .up       (1'b1),
        .tc_val   (SETTLE_LAST),
        .tc       (settle_done)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:                        if (START) state_nxt = APPLY;
            APPLY:                       state_nxt = rv523_selftest_pkg::SETTLE;
            rv523_selftest_pkg::SETTLE:  if (settle_done) state_nxt = SAMPLE;
            SAMPLE:                      state_nxt = (idx == LAST_VEC) ? FINISH : APPLY;
            FINISH:                      state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // y_q in SAMPLE holds Y from the last settle cycle, while the vector was still applied.
    assign mismatch = (y_q != TRUTH[idx]);
    assign err_nxt  = ERR_CNT + {4'd0, mismatch};
    assign running  = (state == APPLY) || (state == rv523_selftest_pkg::SETTLE) || (state == SAMPLE);

    assign BUSY             = running;
    assign DONE             = (state == FINISH);
    assign {A4, A3, A2, A1} = running ? idx : 4'd0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx        <= 4'd0;
            y_q        <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= 5'd0;
            FAIL_VALID <= 1'b0;
            FIRST_FAIL <= 4'd0;
        end else begin
            y_q <= Y;
            if (state == IDLE && START) begin
                idx        <= 4'd0;
                PASS       <= 1'b0;
                ERR_CNT    <= 5'd0;
                FAIL_VALID <= 1'b0;
                FIRST_FAIL <= 4'd0;
            end else if (state == SAMPLE) begin
                ERR_CNT <= err_nxt;
                if (mismatch && !FAIL_VALID) begin
                    FIRST_FAIL <= idx;
                    FAIL_VALID <= 1'b1;
                end
                if (idx == LAST_VEC) begin
                    PASS <= (err_nxt == 5'd0);
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cell4_selftest.sv
// Two engines (NOR4/SETTLE=2 and NAND4/SETTLE=1) driving a faultable cell model, checked every cycle
// against a run-timeline model plus hand-computed expectations for the directed scenarios.
module tb_cell4_selftest;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    logic [1:0] start = 2'b00;
    logic [1:0] y, a1, a2, a3, a4, busy, done, pass, fvld;
    logic [1:0][4:0] err;
    logic [1:0][3:0] ff;
    logic [1:0][3:0] av;

    logic [15:0] tru  [2] = '{16'h0001, 16'h7FFF};
    logic [15:0] flip [2] = '{16'h0000, 16'h0000};
    int          sp   [2] = '{2, 1};

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 CLK = ~CLK;

    assign av[0] = {a4[0], a3[0], a2[0], a1[0]};
    assign av[1] = {a4[1], a3[1], a2[1], a1[1]};
    // Faulty cell: ideal function with the vectors in flip[] inverted.
    assign y[0] = tru[0][av[0]] ^ flip[0][av[0]];
    assign y[1] = tru[1][av[1]] ^ flip[1][av[1]];

    cell4_selftest dut0 (
        .CLK(CLK), .RST_N(RST_N), .START(start[0]), .Y(y[0]),
        .A1(a1[0]), .A2(a2[0]), .A3(a3[0]), .A4(a4[0]),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(err[0]),
        .FAIL_VALID(fvld[0]), .FIRST_FAIL(ff[0])
    );

    cell4_selftest #(.TRUTH(16'h7FFF), .SETTLE(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(start[1]), .Y(y[1]),
        .A1(a1[1]), .A2(a2[1]), .A3(a3[1]), .A4(a4[1]),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(err[1]),
        .FAIL_VALID(fvld[1]), .FIRST_FAIL(ff[1])
    );

    // Model: phase 0 idle, 1 running (tt = cycles since accept), 2 the completion cycle.
    int          ph  [2] = '{0, 0};
    int          tt  [2] = '{0, 0};
    logic [15:0] msk [2] = '{16'h0, 16'h0};
    bit          pv  [2] = '{1'b0, 1'b0};

    initial forever begin
        @(posedge CLK or negedge RST_N);
        for (int k = 0; k < 2; k++) begin
            if (!RST_N) begin
                ph[k] = 0; tt[k] = 0; msk[k] = 16'h0; pv[k] = 1'b0;
            end else if (ph[k] == 0) begin
                if (start[k]) begin
                    ph[k] = 1; tt[k] = 0; msk[k] = flip[k]; pv[k] = 1'b0;
                end
            end else if (ph[k] == 1) begin
                if (tt[k] == 16 * (sp[k] + 2) - 1) begin
                    ph[k] = 2; pv[k] = 1'b1;
                end else begin
                    tt[k] = tt[k] + 1;
                end
            end else begin
                ph[k] = 0;
            end
        end
    end

    task automatic chk(input string nm, input int k, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, k, act, exp_v, $time);
        end
    endtask

    task automatic check_dut(input int k);
        int per, nd, first;
        logic [15:0] lm, m;
        per = sp[k] + 2;
        nd  = (ph[k] == 1) ? tt[k] / per : 16;
        lm  = (nd >= 16) ? 16'hFFFF : 16'((32'd1 << nd) - 32'd1);
        m   = msk[k] & lm;
        first = 0;
        for (int v = 15; v >= 0; v--) if (m[v]) first = v;
        chk("busy",       k, int'(busy[k]), int'(ph[k] == 1));
        chk("done",       k, int'(done[k]), int'(ph[k] == 2));
        chk("a_vec",      k, int'(av[k]),   (ph[k] == 1) ? tt[k] / per : 0);
        chk("err_cnt",    k, int'(err[k]),  $countones(m));
        chk("fail_valid", k, int'(fvld[k]), int'(m != 16'h0));
        chk("first_fail", k, int'(ff[k]),   first);
        chk("pass",       k, int'(pass[k]), int'(ph[k] != 1 && pv[k] && m == 16'h0));
    endtask

    initial forever begin
        @(negedge CLK);
        if (chk_on) begin
            check_dut(0);
            check_dut(1);
        end
    end

    // Run observers: busy/done counts, A sequence on dut0, per-vector hold lengths on dut1.
    int busy_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int av0_q [$];
    int hold1_q [$];
    logic       pb1 = 1'b0;
    logic [3:0] pa1 = 4'd0;

    initial forever begin
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            if (busy[k]) busy_cnt[k]++;
            if (done[k]) done_cnt[k]++;
        end
        if (busy[0] && (av0_q.size() == 0 || av0_q[$] != int'(av[0]))) av0_q.push_back(int'(av[0]));
        if (busy[1]) begin
            if (hold1_q.size() == 0 || !pb1 || pa1 != av[1]) hold1_q.push_back(1);
            else hold1_q[$] = hold1_q[$] + 1;
        end
        pb1 = busy[1];
        pa1 = av[1];
    end

    task automatic clr_mon();
        busy_cnt = '{0, 0};
        done_cnt = '{0, 0};
        av0_q.delete();
        hold1_q.delete();
    endtask

    task automatic pulse(input int k);
        @(posedge CLK); #2 start[k] = 1'b1;
        @(posedge CLK); #2 start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        do begin @(negedge CLK); n++; end while (!done[k] && n < 400);
        chk("done_seen", k, int'(done[k]), 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dc, k;
        logic [15:0] m;

        #1 RST_N = 1'b0;
        #1 chk_on = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 0, int'(busy[0]), 0);
        chk("rst_a",    0, int'(av[0]),   0);
        chk("rst_err",  0, int'(err[0]),  0);
        chk("rst_pass", 0, int'(pass[0]), 0);
        chk("rst_fv",   0, int'(fvld[0]), 0);
        @(posedge CLK); #2 RST_N = 1'b1;

        // Ideal NOR4.
        flip[0] = 16'h0000; clr_mon(); pulse(0); wait_done(0);
        chk("t1_busy_cycles", 0, busy_cnt[0], 64);
        chk("t1_pass", 0, int'(pass[0]), 1);
        chk("t1_err",  0, int'(err[0]),  0);
        chk("t1_fv",   0, int'(fvld[0]), 0);
        chk("t1_seq_len", 0, av0_q.size(), 16);
        for (int i = 0; i < 16; i++) chk("t1_seq", 0, (av0_q.size() > i) ? av0_q[i] : -1, i);

        // Y stuck at 0: only vector 0 (expected 1) mismatches.
        flip[0] = 16'h0001; pulse(0); wait_done(0);
        chk("t2_err",  0, int'(err[0]),  1);
        chk("t2_ff",   0, int'(ff[0]),   0);
        chk("t2_fv",   0, int'(fvld[0]), 1);
        chk("t2_pass", 0, int'(pass[0]), 0);

        // Y stuck at 1: vectors 1..15 mismatch.
        flip[0] = 16'hFFFE; pulse(0); wait_done(0);
        chk("t3_err",  0, int'(err[0]),  15);
        chk("t3_ff",   0, int'(ff[0]),   1);
        chk("t3_pass", 0, int'(pass[0]), 0);

        // NAND4 with SETTLE=1.
        flip[1] = 16'h0000; clr_mon(); pulse(1); wait_done(1);
        chk("t4_busy_cycles", 1, busy_cnt[1], 48);
        chk("t4_pass", 1, int'(pass[1]), 1);
        chk("t4_holds", 1, hold1_q.size(), 16);
        for (int i = 0; i < 16; i++) chk("t4_hold", 1, (hold1_q.size() > i) ? hold1_q[i] : -1, 3);

        // START re-pulsed mid-run is ignored.
        flip[0] = 16'h0000; clr_mon(); pulse(0);
        repeat (18) @(posedge CLK);
        #2 start[0] = 1'b1;
        @(posedge CLK); #2 start[0] = 1'b0;
        wait_done(0);
        chk("t5_busy_cycles", 0, busy_cnt[0], 64);
        repeat (4) @(negedge CLK);
        chk("t5_done_count", 0, done_cnt[0], 1);

        // Asynchronous reset during vector 7.
        flip[0] = 16'hFFFE; clr_mon(); pulse(0);
        n = 0;
        do begin @(negedge CLK); n++; end while (av[0] != 4'd7 && n < 200);
        chk("t6_at_vec7", 0, int'(av[0]), 7);
        chk("t6_err_before", 0, int'(err[0]), 6);
        #2 RST_N = 1'b0;
        #1;
        chk("t6_a",    0, int'(av[0]),   0);
        chk("t6_busy", 0, int'(busy[0]), 0);
        chk("t6_err",  0, int'(err[0]),  0);
        chk("t6_fv",   0, int'(fvld[0]), 0);
        dc = done_cnt[0];
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        chk("t6_no_done", 0, done_cnt[0], dc);
        chk("t6_pass_low", 0, int'(pass[0]), 0);
        flip[0] = 16'h0000; pulse(0); wait_done(0);
        chk("t6_rerun_pass", 0, int'(pass[0]), 1);

        // START held high: back-to-back runs.
        flip[0] = 16'h0420; clr_mon();
        @(posedge CLK); #2 start[0] = 1'b1;
        wait_done(0);
        wait_done(0);
        @(posedge CLK); #2 start[0] = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t7_done_count", 0, done_cnt[0], 2);
        chk("t7_idle", 0, int'(busy[0]), 0);
        chk("t7_err", 0, int'(err[0]), 2);
        chk("t7_ff",  0, int'(ff[0]),  5);

        // Randomized fault masks on both engines.
        for (int r = 0; r < 16; r++) begin
            k = int'($urandom_range(0, 1));
            m = (r % 4 == 0) ? 16'h0000 : 16'($urandom);
            flip[k] = m;
            repeat ($urandom_range(0, 5)) @(posedge CLK);
            pulse(k);
            wait_done(k);
            chk("rnd_err", k, int'(err[k]), $countones(m));
            chk("rnd_pass", k, int'(pass[k]), int'(m == 16'h0));
        end

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
